matrix_result_streamer: RTL
===========================

Name: matrix_result_streamer

Overview:
- Drain stage behind the systolic multiplier.
- Captures the flattened M x P result matrix on the multiplier's one-cycle done pulse and streams it out one element per transfer over a valid/ready interface.
- Element order is row-major by default.
- Feeds a downstream BRAM writer or an output FIFO, freeing the multiplier to start the next job once the capture is taken.

Parameters:
- DATA_WIDTH, 8: width of one result element.
- M, 8: result rows. Must be >= 1.
- P, 8: result columns. Must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- done_in  input  1  one-cycle pulse from the multiplier; result_in is valid in that cycle.
- result_in  input  M*P*DATA_WIDTH  flattened result. Element (r,c) is bits [(r*P+c)*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_data  output  DATA_WIDTH  current element.
- out_row  output  max(1,$clog2(M))  row index of the current element.
- out_col  output  max(1,$clog2(P))  column index of the current element.
- out_last  output  1  high with the final element of the matrix.
- busy  output  1  high from the capture cycle until the final transfer.
- overrun  output  1  sticky; set when a done_in pulse is dropped.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, capture buffer=0, element counter=0.
  - All outputs 0: out_valid, out_data, out_row, out_col, out_last, busy, overrun.
  - Reset mid-stream abandons the matrix; no partial state survives.
- States: IDLE, STREAM.
- IDLE:
  - out_valid=0, busy=0.
  - On done_in: register result_in into the M*P*DATA_WIDTH buffer, clear the counter, go to STREAM.
  - out_valid rises the cycle after done_in, so first-element latency is 1 cycle.
- STREAM:
  - out_valid=1, busy=1.
  - Counter k runs 0..M*P-1; out_row=k/P, out_col=k%P, out_data=buffer element (out_row,out_col).
  - Row and column are kept as separate wrap counters; no divider.
  - On each transfer the counter advances.
  - out_last=1 exactly when k==M*P-1.
  - A transfer with out_last returns the block to IDLE; out_valid is low the next cycle.
- Handshake rules:
  - While out_valid && !out_ready, out_data/out_row/out_col/out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
  - out_valid does not depend combinationally on out_ready.
- done_in in STREAM, not coinciding with the last transfer:
  - Pulse is ignored; the buffer is unchanged.
  - overrun is set to 1 in the next cycle.
- done_in in the same cycle as the last transfer (back-to-back matrices):
  - Accept it: recapture, counter=0, stay in STREAM, out_valid stays 1.
  - No bubble, no overrun.
- overrun: held until clr_overrun or reset. If clr_overrun and a new overrun event occur in the same cycle, set wins.
- M*P==1: first element is also last; out_last=1 on the single beat.
- Throughput: one element per cycle with out_ready held high. Each matrix takes M*P cycles plus 1 cycle capture latency.
- No arithmetic on data; elements pass bit-exact.

Optional Feature:
- Macro: RESULT_STREAM_COL_MAJOR_EN.
- Defined:
  - Elements stream column-major: col outer, row inner, order (0,0),(1,0)..(M-1,0),(0,1)...
  - out_row/out_col still report true indices; out_last is on (M-1,P-1).
  - All handshake, overrun and back-to-back rules are unchanged.
- Not defined: row-major as above.

Test Plan:
- Reset, then M=P=2, DW=8, result_in=elements {00:0x11, 01:0x22, 10:0x33, 11:0x44}, 1-cycle done_in, out_ready=1 -> out_valid rises 1 cycle later. Beats are 0x11(0,0), 0x22(0,1), 0x33(1,0), 0x44(1,1) on consecutive cycles, out_last only on 0x44, busy low after.
- Same matrix, out_ready toggling 1,0,0,1,0,1,1 -> 4 transfers in order; outputs are stable during stalls and out_valid never drops early.
- done_in pulsed again on the 2nd beat -> stream continues with the original data and overrun=1 from the next cycle. clr_overrun -> overrun=0.
- Second done_in (all elements 0x7F) coincident with the last transfer -> the next cycle shows 0x7F at (0,0), out_valid continuous, overrun stays 0.
- rst_n low during beat 2 -> all outputs 0 immediately. After release, IDLE; done_in restarts at (0,0).
- RESULT_STREAM_COL_MAJOR_EN defined, first matrix -> order 0x11, 0x33, 0x22, 0x44, with out_last on 0x44 at (1,1).

Source files
------------

// File: rtl/matrix_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_result_streamer
//  Description : Drain stage behind the systolic multiplier. Captures the
//                flattened M x P result matrix on the one-cycle done pulse
//                and streams it out one element per valid/ready transfer.
//                Row-major by default; define RESULT_STREAM_COL_MAJOR_EN to
//                stream column-major instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_result_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 8,
    parameter int P          = 8,
    localparam int ROW_W     = (M > 1) ? $clog2(M) : 1,
    localparam int COL_W     = (P > 1) ? $clog2(P) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        done_in,
    input  logic [M*P*DATA_WIDTH-1:0]   result_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [ROW_W-1:0]            out_row,
    output logic [COL_W-1:0]            out_col,
    output logic                        out_last,
    output logic                        busy,
    output logic                        overrun,
    input  logic                        clr_overrun
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(M - 1);
    localparam logic [COL_W-1:0] c_col_last = COL_W'(P - 1);

    state_t                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic                    overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]   buf_q  [M][P];
    logic [DATA_WIDTH-1:0]   w_elem [M][P];

    logic w_stream;
    logic w_last;
    logic w_xfer;
    logic w_capture;
    logic w_overrun_event;

    // Unpack the flat result bus into a row/column addressed view.
    genvar gr, gc;
    generate
        for (gr = 0; gr < M; gr++) begin : g_row
            for (gc = 0; gc < P; gc++) begin : g_col
                assign w_elem[gr][gc] = result_in[(gr*P+gc)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    endgenerate

    assign w_stream = (state_q == ST_STREAM);
    // The final element is (M-1,P-1) in either traversal order.
    assign w_last   = w_stream && (row_q == c_row_last) && (col_q == c_col_last);
    assign w_xfer   = w_stream && out_ready;
    // A done pulse is taken when idle, or when it lands on the final transfer
    // so back-to-back matrices stream without a bubble.
    assign w_capture       = done_in && (!w_stream || (w_xfer && w_last));
    assign w_overrun_event = done_in && w_stream && !(w_xfer && w_last);

    // Next-state, index counter and sticky overrun logic.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;

        if (w_capture) begin
            state_d = ST_STREAM;
            row_d   = '0;
            col_d   = '0;
        end else if (w_xfer) begin
            if (w_last) begin
                state_d = ST_IDLE;
                row_d   = '0;
                col_d   = '0;
            end else begin
`ifdef RESULT_STREAM_COL_MAJOR_EN
                // Column-major: row is the inner wrap counter.
                if (row_q == c_row_last) begin
                    row_d = '0;
                    col_d = col_q + COL_W'(1);
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
`else
                // Row-major: column is the inner wrap counter.
                if (col_q == c_col_last) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
`endif
            end
        end

        // A new overrun event takes priority over a clear in the same cycle.
        if (w_overrun_event) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

    // Capture buffer: loaded only when a done pulse is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < P; c++) begin
                    buf_q[r][c] <= '0;
                end
            end
        end else if (w_capture) begin
            buf_q <= w_elem;
        end
    end

    assign out_valid = w_stream;
    assign busy      = w_stream;
    assign out_last  = w_last;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_data  = w_stream ? buf_q[row_q][col_q] : '0;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire
